// File: rtl/sap_core_param.sv
// Parametrised SAP accumulator core: fetch/execute sequencer, A/B/OUT, C/Z flags, external async-read memory.
// Optional single-step gating of T1 is enabled by defining SAP_SINGLE_STEP_EN (adds step / step_wait ports).
//
// state | meaning
// T1    | MAR <= PC (held here while waiting for step when single-stepping)
// T2    | IR <= mem, PC <= PC+1
// T3    | first execute cycle (operand to MAR, LDI, jumps, OUT, HLT)
// T4    | memory execute cycle (LDA load, ADD/SUB B load, STA write)
// T5    | ALU writeback for ADD/SUB
// HALT  | frozen until clr
module sap_core_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              halted,
  output logic              flag_c,
  output logic              flag_z
`ifdef SAP_SINGLE_STEP_EN
  ,
  input  logic              step,
  output logic              step_wait
`endif
);

  typedef enum logic [2:0] {
    S_T1   = 3'd0,
    S_T2   = 3'd1,
    S_T3   = 3'd2,
    S_T4   = 3'd3,
    S_T5   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_STA = 4'd3;
  localparam logic [3:0] OP_LDI = 4'd4;
  localparam logic [3:0] OP_JMP = 4'd5;
  localparam logic [3:0] OP_JC  = 4'd6;
  localparam logic [3:0] OP_JZ  = 4'd7;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_mar;
  logic [DATA_W-1:0]   r_ir;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_out;
  logic                r_c;
  logic                r_z;
  logic                r_halted;
  logic                r_out_valid;

  logic [3:0]          w_opcode;
  logic [ADDR_W-1:0]   w_operand;
  logic                w_sub;
  logic [DATA_W-1:0]   w_b_op;
  logic [DATA_W:0]     w_sum;
  logic                w_step_go;
  logic                w_unused_ir;

  assign w_opcode    = r_ir[DATA_W-1 -: 4];
  assign w_operand   = r_ir[ADDR_W-1:0];
  assign w_unused_ir = ^r_ir;

  // SUB is A + ~B + 1, so the carry-out doubles as "no borrow"
  assign w_sub  = (w_opcode == OP_SUB);
  assign w_b_op = w_sub ? ~r_b : r_b;
  assign w_sum  = {1'b0, r_a} + {1'b0, w_b_op} + (DATA_W+1)'(w_sub);

`ifdef SAP_SINGLE_STEP_EN
  assign w_step_go = step;
  assign step_wait = (r_state == S_T1);
`else
  assign w_step_go = 1'b1;
`endif

  assign mem_addr  = r_mar;
  assign mem_wdata = r_a;
  assign mem_we    = (r_state == S_T4) && (w_opcode == OP_STA);
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign halted    = r_halted;
  assign flag_c    = r_c;
  assign flag_z    = r_z;

  always_comb begin
    w_state_nxt = S_T1;
    case (r_state)
      S_T1:   w_state_nxt = w_step_go ? S_T2 : S_T1;
      S_T2:   w_state_nxt = S_T3;
      S_T3: begin
        case (w_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: w_state_nxt = S_T4;
          OP_HLT:                         w_state_nxt = S_HALT;
          default:                        w_state_nxt = S_T1;
        endcase
      end
      S_T4:   w_state_nxt = (w_opcode == OP_ADD || w_opcode == OP_SUB) ? S_T5 : S_T1;
      S_T5:   w_state_nxt = S_T1;
      S_HALT: w_state_nxt = S_HALT;
      default: w_state_nxt = S_T1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= S_T1;
      r_pc        <= '0;
      r_mar       <= '0;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_out       <= '0;
      r_c         <= 1'b0;
      r_z         <= 1'b0;
      r_halted    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= 1'b0;
      case (r_state)
        S_T1: if (w_step_go) r_mar <= r_pc;
        S_T2: begin
          r_ir <= mem_rdata;
          r_pc <= r_pc + ADDR_W'(1);
        end
        S_T3: begin
          case (w_opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: r_mar <= w_operand;
            OP_LDI: begin
              r_a <= {{(DATA_W-ADDR_W){1'b0}}, w_operand};
              r_z <= (w_operand == '0);
            end
            OP_JMP: r_pc <= w_operand;
            OP_JC:  if (r_c) r_pc <= w_operand;
            OP_JZ:  if (r_z) r_pc <= w_operand;
            OP_OUT: begin
              r_out       <= r_a;
              r_out_valid <= 1'b1;
            end
            OP_HLT: r_halted <= 1'b1;
            default: ;
          endcase
        end
        S_T4: begin
          if (w_opcode == OP_LDA) begin
            r_a <= mem_rdata;
            r_z <= (mem_rdata == '0);
          end else if (w_opcode == OP_ADD || w_opcode == OP_SUB) begin
            r_b <= mem_rdata;
          end
        end
        S_T5: begin
          r_a <= w_sum[DATA_W-1:0];
          r_c <= w_sum[DATA_W];
          r_z <= (w_sum[DATA_W-1:0] == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_core_param.sv
// Bench for sap_core_param: table of ADD/SUB programs plus hand sequences; OUT values checked through a queue.
module tb_sap_core_param;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] out;
  logic          out_valid;
  logic          halted;
  logic          flag_c;
  logic          flag_z;
`ifdef SAP_SINGLE_STEP_EN
  logic          step = 1'b1;
  logic          step_wait;
`endif

  sap_core_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .clr       (clr),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .out       (out),
    .out_valid (out_valid),
    .halted    (halted),
    .flag_c    (flag_c),
    .flag_z    (flag_z)
`ifdef SAP_SINGLE_STEP_EN
    ,
    .step      (step),
    .step_wait (step_wait)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem    [16];
  logic [DW-1:0] ld_img [16];
  logic          ld_en = 1'b0;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (ld_en) begin
      for (int i = 0; i < 16; i++) mem[i] <= ld_img[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= clr ? 0 : edge_cnt + 1;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q[$];
  int we_cnt = 0;
  int ov_cnt = 0;
  int ov_edge = -1;
  logic [AW-1:0] we_addr;
  logic [DW-1:0] we_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every out_valid pulse pops one expected display value
  always @(negedge clk) begin
    if (clr === 1'b0) begin
      if (mem_we === 1'b1) begin
        we_cnt++;
        we_addr = mem_addr;
        we_data = mem_wdata;
      end
      if (out_valid === 1'b1) begin
        ov_cnt++;
        ov_edge = edge_cnt;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL out_unexpected: got out=%0h, expected no out_valid", out);
        end else begin
          chk("out_value", {24'h0, out}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic clear_img();
    for (int i = 0; i < 16; i++) ld_img[i] = 8'hF0;
  endtask

  task automatic do_reset();
    clr   = 1'b1;
    ld_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ld_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    we_cnt  = 0;
    ov_cnt  = 0;
    ov_edge = -1;
    clr     = 1'b0;
  endtask

  task automatic wait_halt(input string name, output int halt_edge);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'h0, halted}, 32'h1);
    halt_edge = edge_cnt;
  endtask

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp_out;
    logic          exp_c;
    logic          exp_z;
  } vec_t;

  vec_t vecs[5];

`ifdef SAP_SINGLE_STEP_EN
  task automatic step_pulse();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (7) @(negedge clk);
  endtask
`endif

  initial begin
    int he;
    logic [DW-1:0] snap_out;
    logic [AW-1:0] snap_addr;
    int we0;

    vecs[0] = '{4'd1, 8'h1C, 8'h0E, 8'h2A, 1'b0, 1'b0};
    vecs[1] = '{4'd2, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{4'd2, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0};
    vecs[3] = '{4'd1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{4'd1, 8'h80, 8'h7F, 8'hFF, 1'b0, 1'b0};

    for (int v = 0; v < 5; v++) begin
      clear_img();
      ld_img[0]  = 8'h09;
      ld_img[1]  = {vecs[v].op, 4'hA};
      ld_img[2]  = 8'hE0;
      ld_img[3]  = 8'hF0;
      ld_img[9]  = vecs[v].a;
      ld_img[10] = vecs[v].b;
      do_reset();
      if (v == 0) begin
        chk("rst_mem_addr", {28'h0, mem_addr}, 32'h0);
        chk("rst_out", {24'h0, out}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_flags", {30'h0, flag_c, flag_z}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
      end
      exp_q.push_back(vecs[v].exp_out);
      wait_halt("alu_halt", he);
      chk("alu_halt_edge", he, 15);
      chk("alu_out_valid_edge", ov_edge, 12);
      chk("alu_out_valid_count", ov_cnt, 1);
      chk("alu_flag_c", {31'h0, flag_c}, {31'h0, vecs[v].exp_c});
      chk("alu_flag_z", {31'h0, flag_z}, {31'h0, vecs[v].exp_z});
      chk("alu_drained", exp_q.size(), 0);
    end

    // Frozen after HLT
    snap_out  = out;
    snap_addr = mem_addr;
    we0       = we_cnt;
    repeat (20) @(negedge clk);
    chk("halt_no_we", we_cnt - we0, 0);
    chk("halt_out_stable", {24'h0, out}, {24'h0, snap_out});
    chk("halt_addr_stable", {28'h0, mem_addr}, {28'h0, snap_addr});
    chk("halt_sticky", {31'h0, halted}, 32'h1);

    // JZ taken
    clear_img();
    ld_img[0] = 8'h40; ld_img[1] = 8'h77; ld_img[2] = 8'hF0;
    ld_img[7] = 8'h4F; ld_img[8] = 8'hE0; ld_img[9] = 8'hF0;
    do_reset();
    exp_q.push_back(8'h0F);
    wait_halt("jz_halt", he);
    chk("jz_drained", exp_q.size(), 0);

    // JC and JZ both not taken (C=0, Z=0)
    clear_img();
    ld_img[0] = 8'h43; ld_img[1] = 8'h67; ld_img[2] = 8'h77;
    ld_img[3] = 8'hE0; ld_img[4] = 8'hF0;
    ld_img[7] = 8'h4F; ld_img[8] = 8'hE0; ld_img[9] = 8'hF0;
    do_reset();
    exp_q.push_back(8'h03);
    wait_halt("nojump_halt", he);
    chk("nojump_drained", exp_q.size(), 0);
    chk("nojump_out_count", ov_cnt, 1);

    // JC taken after an ADD that carries
    clear_img();
    ld_img[0] = 8'h09; ld_img[1] = 8'h1A; ld_img[2] = 8'h67; ld_img[3] = 8'hF0;
    ld_img[7] = 8'hE0; ld_img[8] = 8'hF0; ld_img[9] = 8'hFF; ld_img[10] = 8'h02;
    do_reset();
    exp_q.push_back(8'h01);
    wait_halt("jc_halt", he);
    chk("jc_drained", exp_q.size(), 0);

    // STA then LDA readback
    clear_img();
    ld_img[0] = 8'h49; ld_img[1] = 8'h3C; ld_img[2] = 8'h0C;
    ld_img[3] = 8'hE0; ld_img[4] = 8'hF0; ld_img[12] = 8'h00;
    do_reset();
    exp_q.push_back(8'h09);
    wait_halt("sta_halt", he);
    chk("sta_we_count", we_cnt, 1);
    chk("sta_we_addr", {28'h0, we_addr}, 32'd12);
    chk("sta_we_data", {24'h0, we_data}, 32'h09);
    chk("sta_drained", exp_q.size(), 0);

    // PC wrap: JMP 15, NOP at 15, next fetch from 0
    clear_img();
    for (int i = 1; i < 16; i++) ld_img[i] = 8'h80;
    ld_img[0] = 8'h5F;
    do_reset();
    repeat (4) @(negedge clk);
    chk("wrap_fetch_15", {28'h0, mem_addr}, 32'd15);
    repeat (3) @(negedge clk);
    chk("wrap_fetch_0", {28'h0, mem_addr}, 32'd0);

    // clr while ADD sits in T4
    clear_img();
    ld_img[0] = 8'h40; ld_img[1] = 8'h1A; ld_img[2] = 8'hE0;
    ld_img[3] = 8'hF0; ld_img[10] = 8'h2A;
    do_reset();
    repeat (6) @(negedge clk);
    chk("midadd_mar", {28'h0, mem_addr}, 32'd10);
    chk("midadd_z_before", {31'h0, flag_z}, 32'h1);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midadd_rst_addr", {28'h0, mem_addr}, 32'h0);
    chk("midadd_rst_flags", {30'h0, flag_c, flag_z}, 32'h0);
    chk("midadd_rst_we", {31'h0, mem_we}, 32'h0);
    we_cnt  = 0;
    ov_cnt  = 0;
    clr     = 1'b0;
    exp_q.push_back(8'h2A);
    wait_halt("midadd_halt", he);
    chk("midadd_halt_edge", he, 14);
    chk("midadd_no_write", we_cnt, 0);
    chk("midadd_drained", exp_q.size(), 0);

`ifdef SAP_SINGLE_STEP_EN
    clear_img();
    ld_img[0] = 8'h45; ld_img[1] = 8'hE0; ld_img[2] = 8'h46;
    ld_img[3] = 8'hE0; ld_img[4] = 8'hF0;
    step = 1'b0;
    do_reset();
    repeat (5) @(negedge clk);
    chk("step_wait_idle", {31'h0, step_wait}, 32'h1);
    step_pulse();
    chk("step_wait_after_ldi", {31'h0, step_wait}, 32'h1);
    chk("step_no_out_yet", ov_cnt, 0);
    exp_q.push_back(8'h05);
    step_pulse();
    chk("step_out1_count", ov_cnt, 1);
    step_pulse();
    chk("step_ldi2_out_held", {24'h0, out}, 32'h05);
    exp_q.push_back(8'h06);
    step_pulse();
    chk("step_out2_count", ov_cnt, 2);
    step_pulse();
    chk("step_halted", {31'h0, halted}, 32'h1);
    chk("step_drained", exp_q.size(), 0);
    step = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
